image_out_framer: RTL and testbench
===================================

// Module: image_out_framer
// PURPOSE
//   Sink end of the pixel pipeline: takes the 8-bit convolved pixel stream (valid-only, no stall)
//   leaving the image-process top, and turns it into a framed, back-pressurable 32-bit word stream.
//   - Packs PACK pixels per word.
//   - Marks start-of-frame (tuser) and end-of-row (tlast).
//   - Buffers in a FIFO.
//   - Flags overflow.
//   - Pulses frame-done for the DMA/host interrupt.
// PARAMETERS
//   OUT_W       512  pixels per output row; must be a multiple of PACK
//   OUT_H       512  rows per output frame
//   PACK        4    pixels per output word (fixed 4 -> 32-bit word)
//   FIFO_DEPTH  16   output FIFO depth in words (power of 2, >=2)
// PORTS
//   i_clk         in   1   clock; all logic on rising edge
//   i_rst         in   1   asynchronous, active-high reset
//   i_data_valid  in   1   convolved pixel valid; cannot be stalled
//   i_data        in   8   convolved pixel
//   o_tdata       out  32  packed word; first pixel of the word in [7:0], last in [31:24]
//   o_tvalid      out  1   word available (FIFO not empty)
//   i_tready      in   1   downstream accepts; handshake = o_tvalid & i_tready
//   o_tlast       out  1   word is the last of a row
//   o_tuser       out  1   word is the first of a frame
//   o_frame_done  out  1   1-cycle pulse on the handshake of a frame's last word
//   o_overflow    out  1   sticky: a word was dropped because the FIFO was full
// BEHAVIOUR
//   - Reset (async assert, sync release): all outputs 0, pack lane/col/row counters 0, FIFO empty, overflow clear.
//     Reset mid-frame discards partial word and FIFO contents; the first pixel after reset is row 0, col 0.
//   - Packing:
//     - Each valid pixel is written to lane `lane`; lane, col and row counters advance.
//     - col wraps OUT_W-1 -> 0 and increments row.
//     - row wraps OUT_H-1 -> 0.
//     - When lane == PACK-1 the word is complete and is pushed at that same edge, with sideband:
//       sof = (row==0 & word is first of row 0), eol = (col==OUT_W-1), eof = eol & (row==OUT_H-1).
//   - Latency: if the FIFO is empty, o_tvalid rises the cycle after the 4th pixel's valid cycle.
//   - FIFO:
//     - Push is allowed when !full, or when full and a pop happens in the same cycle.
//     - Otherwise the word is dropped and o_overflow is set.
//     - Counters always advance so frame geometry stays aligned.
//     - o_overflow is cleared only by i_rst.
//     - o_tdata, o_tlast and o_tuser come from the FIFO head (first-word-fall-through) and hold stable while o_tvalid & !i_tready.
//   - o_frame_done pulses in the cycle after the handshake of a word whose eof bit is set.
//   - Pixels keep arriving during drain; they belong to the next frame and are handled normally.
//   - i_data_valid gaps of any length are allowed; only valid cycles advance counters.
// CONFIGURATION
//   - IMG_OUT_STATS_EN defined: adds ports o_frame_count(16) and o_drop_count(16), both reset to 0.
//     - o_frame_count increments on each o_frame_done pulse and wraps at 0xFFFF.
//     - o_drop_count increments per dropped word and saturates at 0xFFFF.
//   - IMG_OUT_STATS_EN undefined: these ports and their counters are absent; all other behaviour is identical.
// STRUCTURE
//   - Shared package img_pkg: PIX_W=8, WORD_W=32, typedef img_sb_t {sof, eol, eof}, and the default OUT_W/OUT_H constants.
//   - Sub-module img_out_fifo: synchronous first-word-fall-through FIFO, width WORD_W+3, depth FIFO_DEPTH.
//     - Ports: push, pop, full, empty.
//     - Simultaneous push+pop when full is legal.
//   - Top holds the lane/col/row counters, the packing register, overflow/frame-done logic and the optional stats.
// TESTING (OUT_W=8, OUT_H=2, PACK=4 unless noted)
//   1. Reset release, no input -> o_tvalid=0, o_overflow=0, o_frame_done=0 for 20 cycles.
//   2. Pixels 0x00..0x0F back-to-back, i_tready=1 -> words 0x03020100 (tuser=1), 0x07060504 (tlast=1),
//      0x0B0A0908, 0x0F0E0D0C (tlast=1); o_frame_done pulses once, after the 4th handshake.
//   3. FIFO_DEPTH=4, i_tready=0, 20 pixels -> 4 words held, 5th dropped, o_overflow=1.
//      Then i_tready=1 -> 4 words drain in order; the next frame's first word has tuser=1.
//   4. FIFO full, i_tready=1, and the 4th pixel of a new word arrives in the same cycle -> word pushed, no drop, o_overflow stays 0.
//   5. i_rst asserted after 6 pixels of a frame, then 16 fresh pixels 0x40.. -> first word 0x43424140 with tuser=1; no stale data appears.
//   6. IMG_OUT_STATS_EN defined, scenario 3 then two full frames -> o_drop_count=1, o_frame_count increments by 1 per frame.

Source files
------------

// File: rtl/img_pkg.sv
// Shared definitions for the image output path.
//   PIX_W / WORD_W     : pixel and packed-word widths
//   OUT_W_DEF/OUT_H_DEF: default output frame geometry
//   img_sb_t           : per-word sideband carried through the output FIFO
//   cnt_w()            : counter width helper that never returns 0
package img_pkg;

  localparam int PIX_W     = 8;
  localparam int WORD_W    = 32;
  localparam int OUT_W_DEF = 512;
  localparam int OUT_H_DEF = 512;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } img_sb_t;

  localparam int SB_W = $bits(img_sb_t);

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/img_out_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   i_clk, i_rst : clock, asynchronous active-high reset (pointers/count only)
//   push, i_wdata: write request and data (ignored when full unless popping)
//   pop          : read request; o_rdata always shows the head entry
//   full, empty  : occupancy flags
// A push and a pop in the same cycle while full is legal: the head leaves and
// the new word takes the freed slot.
module img_out_fifo
  import img_pkg::*;
#(
  parameter int WIDTH = WORD_W + SB_W,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign o_rdata = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/image_out_framer.sv
// Sink end of the pixel pipeline: packs PACK 8-bit pixels per 32-bit word,
// tags start-of-frame (tuser) and end-of-row (tlast), buffers words in a FWFT
// FIFO and presents them on a valid/ready stream.
//   i_clk, i_rst             : clock, asynchronous active-high reset
//   i_data_valid, i_data     : pixel stream, cannot be stalled
//   o_tdata/o_tvalid/i_tready: packed word stream, first pixel in [7:0]
//   o_tlast, o_tuser         : end-of-row / start-of-frame word markers
//   o_frame_done             : 1-cycle pulse after the handshake of a frame's last word
//   o_overflow               : sticky, set when a completed word found the FIFO full
// Optional macro IMG_OUT_STATS_EN adds o_frame_count (wrapping) and
// o_drop_count (saturating), both 16 bits.
module image_out_framer
  import img_pkg::*;
#(
  parameter int OUT_W      = OUT_W_DEF,
  parameter int OUT_H      = OUT_H_DEF,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_data_valid,
  input  logic [PIX_W-1:0]  i_data,
  output logic [WORD_W-1:0] o_tdata,
  output logic              o_tvalid,
  input  logic              i_tready,
  output logic              o_tlast,
  output logic              o_tuser,
  output logic              o_frame_done,
  output logic              o_overflow
`ifdef IMG_OUT_STATS_EN
  ,
  output logic [15:0]       o_frame_count,
  output logic [15:0]       o_drop_count
`endif
);

  localparam int LANE_W = cnt_w(PACK);
  localparam int COL_W  = cnt_w(OUT_W);
  localparam int ROW_W  = cnt_w(OUT_H);
  localparam int FW     = WORD_W + SB_W;

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic              overflow_q, overflow_d;
  logic              frame_done_q, frame_done_d;

  logic              push;
  logic [WORD_W-1:0] word;
  img_sb_t           sb;
  logic              pop, full, empty, drop;
  logic [FW-1:0]     rdata;
  img_sb_t           head_sb;

  // Packing: lane/col/row advance only on valid pixels. The completing pixel
  // goes straight into the pushed word so the push lands on its own edge.
  always_comb begin
    lane_d = lane_q;
    col_d  = col_q;
    row_d  = row_q;
    pack_d = pack_q;
    push   = 1'b0;
    word   = pack_q;
    sb     = '0;
    if (i_data_valid) begin
      pack_d[lane_q*PIX_W +: PIX_W] = i_data;
      if (col_q == COL_W'(OUT_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(OUT_H - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      if (lane_q == LANE_W'(PACK - 1)) begin
        lane_d = '0;
        push   = 1'b1;
        word[(PACK-1)*PIX_W +: PIX_W] = i_data;
        // col_q is the column of the word's last pixel here.
        sb.sof = (row_q == '0) && (col_q == COL_W'(PACK - 1));
        sb.eol = (col_q == COL_W'(OUT_W - 1));
        sb.eof = sb.eol && (row_q == ROW_W'(OUT_H - 1));
      end else begin
        lane_d = lane_q + LANE_W'(1);
      end
    end
  end

  img_out_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .push    (push),
    .i_wdata ({sb, word}),
    .pop     (pop),
    .o_rdata (rdata),
    .full    (full),
    .empty   (empty)
  );

  assign head_sb  = img_sb_t'(rdata[WORD_W +: SB_W]);
  assign o_tvalid = !empty;
  assign pop      = o_tvalid && i_tready;
  assign drop     = push && full && !pop;

  // Head fields are forced to 0 when empty so stale/unwritten storage never shows.
  assign o_tdata = empty ? '0 : rdata[WORD_W-1:0];
  assign o_tlast = !empty && head_sb.eol;
  assign o_tuser = !empty && head_sb.sof;

  always_comb begin
    overflow_d   = overflow_q || drop;
    frame_done_d = pop && head_sb.eof;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lane_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      col_q        <= col_d;
      row_q        <= row_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Partial-word data needs no reset: lane restarts at 0 and overwrites it.
  always_ff @(posedge i_clk) begin
    pack_q <= pack_d;
  end

  assign o_overflow   = overflow_q;
  assign o_frame_done = frame_done_q;

`ifdef IMG_OUT_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    if (frame_done_q) frame_count_d = frame_count_q + 16'd1;
    if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign o_frame_count = frame_count_q;
  assign o_drop_count  = drop_count_q;
`endif

endmodule

// File: tb/tb_image_out_framer.sv
// Testbench for image_out_framer (OUT_W=8, OUT_H=2, PACK=4, FIFO_DEPTH=4).
// Reference model: pixel index within the frame plus a bounded word queue.
module tb_image_out_framer;

  localparam int OUT_W = 8;
  localparam int OUT_H = 2;
  localparam int PACK  = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = OUT_W * OUT_H;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_data_valid = 1'b0;
  logic [7:0]  i_data = '0;
  logic        i_tready = 1'b0;
  logic [31:0] o_tdata;
  logic        o_tvalid, o_tlast, o_tuser, o_frame_done, o_overflow;
`ifdef IMG_OUT_STATS_EN
  logic [15:0] o_frame_count, o_drop_count;
`endif

  always #5 i_clk = ~i_clk;

  image_out_framer #(
    .OUT_W      (OUT_W),
    .OUT_H      (OUT_H),
    .PACK       (PACK),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data_valid (i_data_valid),
    .i_data       (i_data),
    .o_tdata      (o_tdata),
    .o_tvalid     (o_tvalid),
    .i_tready     (i_tready),
    .o_tlast      (o_tlast),
    .o_tuser      (o_tuser),
    .o_frame_done (o_frame_done),
    .o_overflow   (o_overflow)
`ifdef IMG_OUT_STATS_EN
    ,
    .o_frame_count (o_frame_count),
    .o_drop_count  (o_drop_count)
`endif
  );

  typedef struct {
    logic [31:0] data;
    bit          sof;
    bit          eol;
    bit          eof;
  } wd_t;

  wd_t         mq[$];
  logic [31:0] log_d[$];
  bit          log_u[$];
  bit          log_l[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_pix, m_frames, m_drops, fd_seen;
  logic [31:0] m_word;
  bit          m_ovf, m_fd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_pix = 0; m_word = '0; m_ovf = 0; m_fd = 0;
    m_frames = 0; m_drops = 0; fd_seen = 0;
  endtask

  task automatic log_clear();
    log_d.delete(); log_u.delete(); log_l.delete();
  endtask

  // One clock: apply inputs, advance the model for the coming edge, then check.
  task automatic cycle(input bit v, input logic [7:0] d, input bit rdy);
    bit  pop, full0;
    wd_t w;
    i_data_valid = v;
    i_data       = d;
    i_tready     = rdy;
    if (o_tvalid && rdy) begin
      log_d.push_back(o_tdata); log_u.push_back(o_tuser); log_l.push_back(o_tlast);
    end
    if (m_fd) m_frames = (m_frames + 1) & 16'hFFFF;
    full0 = (mq.size() == DEPTH);
    pop   = (mq.size() > 0) && rdy;
    m_fd  = pop && mq[0].eof;
    if (pop) void'(mq.pop_front());
    if (v) begin
      m_word[(m_pix % PACK)*8 +: 8] = d;
      if (m_pix % PACK == PACK - 1) begin
        w.data = m_word;
        w.sof  = (m_pix == PACK - 1);
        w.eol  = (m_pix % OUT_W == OUT_W - 1);
        w.eof  = (m_pix == FRAME - 1);
        if (!full0 || pop) mq.push_back(w);
        else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
      end
      m_pix = (m_pix + 1) % FRAME;
    end
    @(posedge i_clk);
    #1;
    chk("tvalid", o_tvalid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("tdata", o_tdata, mq[0].data);
      chk("tlast", o_tlast, mq[0].eol);
      chk("tuser", o_tuser, mq[0].sof);
    end
    chk("overflow", o_overflow, m_ovf);
    chk("frame_done", o_frame_done, m_fd);
    if (o_frame_done) fd_seen++;
`ifdef IMG_OUT_STATS_EN
    chk("frame_count", o_frame_count, m_frames);
    chk("drop_count", o_drop_count, m_drops);
`endif
  endtask

  task automatic do_reset();
    i_data_valid = 0;
    i_tready     = 0;
    i_rst        = 1;
    #2;
    chk("rst_tvalid", o_tvalid, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_frame_done", o_frame_done, 0);
    @(posedge i_clk);
    #1;
    i_rst = 0;
    model_clear();
    log_clear();
  endtask

  logic [31:0] s2_exp [4];
  bit          s2_last [4];

  initial begin
    s2_exp  = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    s2_last = '{0, 1, 0, 1};
    model_clear();
    @(posedge i_clk);
    #1;
    do_reset();

    // 1: idle after reset
    for (int i = 0; i < 20; i++) cycle(0, 8'h00, 1);

    // 2: one frame back-to-back, always ready
    log_clear(); fd_seen = 0;
    for (int i = 0; i < 16; i++) cycle(1, 8'(i), 1);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1);
    chk("s2_words", log_d.size(), 4);
    if (log_d.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("s2_tdata", log_d[i], s2_exp[i]);
        chk("s2_tlast", log_l[i], s2_last[i]);
        chk("s2_tuser", log_u[i], (i == 0));
      end
    chk("s2_frame_done_cnt", fd_seen, 1);

    // 3 (+6): overflow with a 4-deep FIFO, then drain and run two frames
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1, 8'($urandom), 0);
    chk("s3_overflow", o_overflow, 1);
    chk("s3_tvalid", o_tvalid, 1);
    for (int i = 0; i < 6; i++) cycle(0, 8'h00, 1);
    for (int i = 0; i < 16; i++) cycle(1, 8'($urandom), 1);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1);
    chk("s3_words", log_d.size(), 8);
    if (log_d.size() == 8) begin
      chk("s3_first_tuser", log_u[0], 1);
      chk("s3_mid_tuser", log_u[4], 0);
      chk("s3_next_frame_tuser", log_u[7], 1);
    end
    for (int i = 0; i < 2 * FRAME; i++) cycle(1, 8'($urandom), 1);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1);
`ifdef IMG_OUT_STATS_EN
    chk("s6_drop_count", o_drop_count, 1);
`endif

    // 4: FIFO full, word completes while a pop frees a slot
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, 8'(i + 8'h20), 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'(i + 8'h30), 0);
    chk("s4_full_tvalid", o_tvalid, 1);
    cycle(1, 8'h33, 1);
    chk("s4_overflow", o_overflow, 0);
    for (int i = 0; i < 6; i++) cycle(0, 8'h00, 1);

    // 5: reset mid-frame discards partial word
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 8'(i + 8'h10), 1);
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, 8'(8'h40 + i), 1);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1);
    chk("s5_words", log_d.size(), 4);
    if (log_d.size() > 0) begin
      chk("s5_first_word", log_d[0], 32'h43424140);
      chk("s5_first_tuser", log_u[0], 1);
    end

    // Random gaps and back-pressure, including a starved-ready phase
    do_reset();
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0);
    for (int i = 0; i < 10; i++) cycle(0, 8'h00, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
